bpred_btb: RTL and testbench

- Parametrised branch predictor for the pipelined MIPS core: a direct-mapped branch target buffer plus a 2-bit saturating direction counter per entry.
- IF looks up the predicted next PC combinationally from the current PC.
- ID/EXE, where branch/jump/jal/jr resolve, trains the table one update per cycle.
- Replaces the fixed "predict not taken plus flush" scheme with a taken/target prediction.

---
 rtl/bpred_btb_if.sv | 29 ++
 rtl/bpred_btb.sv | 164 ++++++++++++++++
 tb/tb_bpred_btb.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bpred_btb_if.sv
// Lookup/update bundle between the fetch/resolve stages and the branch target buffer.
// master = core side (drives PC and training), slave = bpred_btb.
`timescale 1ns/1ps
interface bpred_btb_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] if_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_is_jump;

  modport master (
    output if_pc,
    output upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump,
    input  pred_hit, pred_taken, pred_target
  );

  modport slave (
    input  if_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump,
    output pred_hit, pred_taken, pred_target
  );
endinterface

// File: rtl/bpred_btb.sv
// Direct-mapped branch target buffer with a 2-bit direction counter per entry.
// Optional BPRED_STATS_EN adds saturating update / misprediction counters.
`timescale 1ns/1ps
module bpred_btb #(
  parameter int XLEN   = 32,
  parameter int IDX_W  = 4,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  bpred_btb_if.slave        bif
`ifdef BPRED_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_updates,
  output logic [STAT_W-1:0] stat_mispred
`endif
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_W   = XLEN - IDX_W - 2;

  // Table kept in flops so the asynchronous reset can clear every entry at once.
  logic [ENTRIES-1:0]            valid_vec;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_vec;
  logic [ENTRIES-1:0][XLEN-1:0]  target_vec;
  logic [ENTRIES-1:0][1:0]       ctr_vec;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [XLEN-1:0]  lk_pc_plus4;

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_eff_taken;
  logic             upd_hit;
  logic [1:0]       old_ctr;
  logic [XLEN-1:0]  old_target;
  logic [1:0]       new_ctr;
  logic [XLEN-1:0]  new_target;
  logic             wr_en;
  logic [ENTRIES-1:0] wr_sel;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bif.if_pc[1:0], bif.upd_pc[1:0]};

  // ---------------------------------------------------------------- lookup
  assign lk_idx      = bif.if_pc[IDX_W+1:2];
  assign lk_tag      = bif.if_pc[XLEN-1:IDX_W+2];
  assign lk_pc_plus4 = bif.if_pc + XLEN'(4);

  always_comb begin
    lk_hit          = valid_vec[lk_idx] && (tag_vec[lk_idx] == lk_tag);
    bif.pred_hit    = lk_hit;
    bif.pred_taken  = lk_hit & ctr_vec[lk_idx][1];
    bif.pred_target = bif.pred_taken ? target_vec[lk_idx] : lk_pc_plus4;
  end

  // ---------------------------------------------------------------- training
  assign upd_idx = bif.upd_pc[IDX_W+1:2];
  assign upd_tag = bif.upd_pc[XLEN-1:IDX_W+2];

  // A jump reported as not-taken is malformed; treat it as taken.
  assign upd_eff_taken = bif.upd_taken | bif.upd_is_jump;

  always_comb begin
    upd_hit    = valid_vec[upd_idx] && (tag_vec[upd_idx] == upd_tag);
    old_ctr    = ctr_vec[upd_idx];
    old_target = target_vec[upd_idx];
    new_ctr    = old_ctr;
    new_target = old_target;
    wr_en      = 1'b0;

    if (bif.upd_valid) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (bif.upd_is_jump) begin
          new_ctr = 2'd3;
        end else if (upd_eff_taken) begin
          new_ctr = (old_ctr == 2'd3) ? 2'd3 : old_ctr + 2'd1;
        end else begin
          new_ctr = (old_ctr == 2'd0) ? 2'd0 : old_ctr - 2'd1;
        end
        if (upd_eff_taken) begin
          new_target = bif.upd_target;
        end
      end else if (upd_eff_taken) begin
        // Miss on a taken transfer: evict whatever lives at this index.
        wr_en      = 1'b1;
        new_ctr    = bif.upd_is_jump ? 2'd3 : 2'd2;
        new_target = bif.upd_target;
      end
    end
  end

  always_comb begin
    wr_sel          = '0;
    wr_sel[upd_idx] = wr_en;
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic             valid_reg;
      logic [TAG_W-1:0] tag_reg;
      logic [XLEN-1:0]  target_reg;
      logic [1:0]       ctr_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg  <= 1'b0;
          tag_reg    <= '0;
          target_reg <= '0;
          ctr_reg    <= 2'd1;
        end else if (wr_sel[gi]) begin
          valid_reg  <= 1'b1;
          tag_reg    <= upd_tag;
          target_reg <= new_target;
          ctr_reg    <= new_ctr;
        end
      end

      assign valid_vec[gi]  = valid_reg;
      assign tag_vec[gi]    = tag_reg;
      assign target_vec[gi] = target_reg;
      assign ctr_vec[gi]    = ctr_reg;
    end
  endgenerate

`ifdef BPRED_STATS_EN
  // ---------------------------------------------------------------- statistics
  logic              upd_pred_taken;
  logic              upd_mispred;
  logic [STAT_W-1:0] stat_updates_reg;
  logic [STAT_W-1:0] stat_mispred_reg;

  // Misprediction is judged against what IF would have seen from the pre-update table.
  always_comb begin
    upd_pred_taken = upd_hit & old_ctr[1];
    upd_mispred    = (upd_pred_taken != upd_eff_taken) ||
                     (upd_pred_taken && upd_eff_taken && (old_target != bif.upd_target));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_updates_reg <= '0;
      stat_mispred_reg <= '0;
    end else if (bif.upd_valid) begin
      if (stat_updates_reg != '1) begin
        stat_updates_reg <= stat_updates_reg + STAT_W'(1);
      end
      if (upd_mispred && (stat_mispred_reg != '1)) begin
        stat_mispred_reg <= stat_mispred_reg + STAT_W'(1);
      end
    end
  end

  assign stat_updates = stat_updates_reg;
  assign stat_mispred = stat_mispred_reg;
`else
  localparam int unused_stat_w = STAT_W;
`endif

endmodule

// File: tb/tb_bpred_btb.sv
// Randomised + directed scoreboard bench for bpred_btb against an index/tag table model.
`timescale 1ns/1ps
module tb_bpred_btb;
  localparam int XLEN    = 32;
  localparam int IDX_W   = 4;
  localparam int STAT_W  = 32;
  localparam int ENTRIES = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bpred_btb_if #(.XLEN(XLEN)) bif ();
`ifdef BPRED_STATS_EN
  logic [STAT_W-1:0] stat_updates;
  logic [STAT_W-1:0] stat_mispred;
`endif

  bpred_btb #(.XLEN(XLEN), .IDX_W(IDX_W), .STAT_W(STAT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
`ifdef BPRED_STATS_EN
    ,
    .stat_updates (stat_updates),
    .stat_mispred (stat_mispred)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic [31:0] su;
    logic [31:0] sm;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  bit   chk_valid = 0;

  // Reference model: one record per index, keyed by plain pc arithmetic.
  bit          m_valid[ENTRIES];
  int unsigned m_tag[ENTRIES];
  logic [31:0] m_tgt[ENTRIES];
  int          m_ctr[ENTRIES];
  longint unsigned m_updates;
  longint unsigned m_mispred;
  longint unsigned stat_max = (64'd1 << STAT_W) - 1;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    int unsigned p = pc;
    return (p / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    int unsigned p = pc;
    return p / (4 * ENTRIES);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_tgt[i]   = 32'h0;
      m_ctr[i]   = 1;
    end
    m_updates = 0;
    m_mispred = 0;
  endfunction

  function automatic exp_t model_lookup(input logic [31:0] pc);
    exp_t e;
    int unsigned i = idx_of(pc);
    e.pc     = pc;
    e.hit    = m_valid[i] && (m_tag[i] == tag_of(pc));
    e.taken  = e.hit && (m_ctr[i] >= 2);
    e.target = e.taken ? m_tgt[i] : pc + 32'd4;
    e.su     = 32'(m_updates);
    e.sm     = 32'(m_mispred);
    return e;
  endfunction

  function automatic void model_update(input logic [31:0] pc, input bit taken,
                                       input logic [31:0] tgt, input bit jump);
    int unsigned i   = idx_of(pc);
    bit          eff = taken || jump;
    bit          hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    bit          ptk = hit && (m_ctr[i] >= 2);
    if (m_updates < stat_max) m_updates++;
    if (((ptk != eff) || (ptk && eff && m_tgt[i] != tgt)) && m_mispred < stat_max) m_mispred++;
    if (hit) begin
      if (jump)      m_ctr[i] = 3;
      else if (eff)  m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
      else           m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      if (eff) m_tgt[i] = tgt;
    end else if (eff) begin
      m_valid[i] = 1;
      m_tag[i]   = tag_of(pc);
      m_tgt[i]   = tgt;
      m_ctr[i]   = jump ? 3 : 2;
    end
  endfunction

  function automatic void cmp(input string name, input logic [31:0] pc,
                              input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s pc=%08h got=%08h want=%08h", name, pc, act, want);
    end
  endfunction

  // Monitor: consumes one expectation per presented lookup.
  always @(negedge clk) begin
    if (chk_valid) begin
      chk_valid = 0;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty got=lookup want=expectation");
      end else begin
        mon_e = exp_q.pop_front();
        cmp("hit",    mon_e.pc, {31'd0, bif.pred_hit},   {31'd0, mon_e.hit});
        cmp("taken",  mon_e.pc, {31'd0, bif.pred_taken}, {31'd0, mon_e.taken});
        cmp("target", mon_e.pc, bif.pred_target,         mon_e.target);
`ifdef BPRED_STATS_EN
        cmp("stat_updates", mon_e.pc, stat_updates, mon_e.su);
        cmp("stat_mispred", mon_e.pc, stat_mispred, mon_e.sm);
`endif
        $display("txn pc=%08h hit=%0b taken=%0b target=%08h", mon_e.pc,
                 bif.pred_hit, bif.pred_taken, bif.pred_target);
      end
    end
  end

  task automatic step(input logic [31:0] pc, input bit uv, input logic [31:0] upc,
                      input bit ut, input logic [31:0] utg, input bit uj);
    @(posedge clk);
    #1;
    bif.if_pc       = pc;
    bif.upd_valid   = uv;
    bif.upd_pc      = upc;
    bif.upd_taken   = ut;
    bif.upd_target  = utg;
    bif.upd_is_jump = uj;
    exp_q.push_back(model_lookup(pc));
    if (uv) model_update(upc, ut, utg, uj);
    chk_valid = 1;
  endtask

  // Reset lands between edges while a taken update is pending; that update is lost.
  task automatic async_reset_mid(input logic [31:0] pc, input logic [31:0] upc,
                                 input logic [31:0] utg);
    @(posedge clk);
    #1;
    bif.if_pc       = pc;
    bif.upd_valid   = 1'b1;
    bif.upd_pc      = upc;
    bif.upd_taken   = 1'b1;
    bif.upd_target  = utg;
    bif.upd_is_jump = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    exp_q.push_back(model_lookup(pc));
    chk_valid = 1;
    @(posedge clk);
    #1;
    bif.upd_valid = 1'b0;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] pool_pc();
    logic [31:0] p;
    p = 32'h0040_0000 | (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 2)
        | 32'($urandom_range(0, 3));
    return p;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    a = 32'h0040_0010;
    bif.if_pc = 32'h0; bif.upd_valid = 1'b0; bif.upd_pc = 32'h0;
    bif.upd_taken = 1'b0; bif.upd_target = 32'h0; bif.upd_is_jump = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Allocation and counter walk on one entry
    step(a, 0, 0, 0, 0, 0);
    step(a, 1, a, 1, 32'h0040_0000, 0);
    step(a, 1, a, 0, 32'h0, 0);
    step(a, 1, a, 0, 32'h0, 0);
    step(a, 1, a, 0, 32'h0, 0);
    step(a, 1, a, 1, 32'h0040_0000, 0);
    step(a, 0, 0, 0, 0, 0);
    // Aliasing on index 4 and a not-taken miss
    step(a, 1, 32'h0040_0050, 1, 32'h0040_1000, 0);
    step(a, 0, 0, 0, 0, 0);
    step(32'h0040_0050, 1, 32'h0040_0090, 0, 32'h0040_2000, 0);
    step(32'h0040_0090, 0, 0, 0, 0, 0);
    step(32'h0040_0050, 0, 0, 0, 0, 0);
    // Jump allocation with same-cycle lookup, then a not-taken training
    step(32'h0040_0020, 1, 32'h0040_0020, 1, 32'h0040_0100, 1);
    step(32'h0040_0020, 1, 32'h0040_0020, 0, 32'h0040_0200, 0);
    step(32'h0040_0020, 0, 0, 0, 0, 0);
    // PC+4 wrap and jump-reported-not-taken
    step(32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    step(32'h0040_0030, 1, 32'h0040_0030, 0, 32'h0040_0300, 1);
    step(32'h0040_0030, 0, 0, 0, 0, 0);
    // Asynchronous reset mid-update
    async_reset_mid(32'h0040_0020, 32'h0040_0040, 32'h0040_0400);
    step(32'h0040_0040, 0, 0, 0, 0, 0);
    step(32'h0040_0020, 0, 0, 0, 0, 0);

    for (int n = 0; n < 600; n++) begin
      logic [31:0] lpc;
      lpc = ($urandom_range(0, 9) == 0) ? $urandom : pool_pc();
      if ($urandom_range(0, 149) == 0) begin
        async_reset_mid(lpc, pool_pc(), $urandom & 32'hFFFF_FFFC);
      end else begin
        step(lpc, $urandom_range(0, 3) != 0, pool_pc(), $urandom_range(0, 1) == 1,
             $urandom & 32'hFFFF_FFFC, $urandom_range(0, 7) == 0);
      end
    end

    @(posedge clk);
    #1 bif.upd_valid = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
